// File: rtl/valtrain_pkg.sv
// Shared valid-lane training definitions: base byte, pattern width, checker states
// and the rotated training pattern used by both transmitter and receiver checker.
package valtrain_pkg;

   localparam int VT_PAT_W = 32;
   localparam logic [7:0] VT_BASE_BYTE = 8'hF0;

   // Unrotated word the transmitter sends during valid-lane training.
   localparam logic [VT_PAT_W-1:0] VT_TX_PATTERN = {4{VT_BASE_BYTE}};

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_CHECK = 2'd1,
      ST_DONE  = 2'd2
   } vt_state_e;

   // Base byte rotated right by rot, replicated across the word.
   function automatic logic [VT_PAT_W-1:0] vt_pattern(input logic [2:0] rot);
      logic [15:0] dbl;
      dbl = {VT_BASE_BYTE, VT_BASE_BYTE} >> rot;
      return {4{dbl[7:0]}};
   endfunction

endpackage

// File: rtl/valtrain_rot_match.sv
// Combinational search of a received word against all eight pattern rotations.
// Zero latency; reports the lowest matching rotation.
module valtrain_rot_match
   import valtrain_pkg::*;
(
   input  logic [VT_PAT_W-1:0] i_word,
   output logic                o_match,
   output logic [2:0]          o_rot
);

   // Descending scan so the lowest matching rotation is the last one written.
   always_comb begin
      o_match = 1'b0;
      o_rot   = 3'd0;
      for (int r = 7; r >= 0; r--) begin
         if (i_word == vt_pattern(3'(r))) begin
            o_match = 1'b1;
            o_rot   = 3'(r);
         end
      end
   end

endmodule

// File: rtl/valtrain_checker.sv
// Valid-lane training checker: locks a pattern rotation, counts mismatches over MAX_ITER words.
// All outputs registered; o_done one cycle after the last strobed word; strobes only, no backpressure.
module valtrain_checker
   import valtrain_pkg::*;
#(
   parameter int unsigned MAX_ITER      = 128,
   parameter int unsigned ERR_THRESHOLD = 16
)(
   input  logic        i_clk,
   input  logic        i_rst_n,
   input  logic        i_enable,
   input  logic        i_rvld_strobe,
   input  logic [31:0] i_RVLD_L,
   output logic        o_done,
   output logic        o_pass,
   output logic [7:0]  o_err_count,
   output logic        o_locked,
   output logic [2:0]  o_lock_rot
);

   localparam int IW = $clog2(MAX_ITER) + 1;
   localparam logic [IW-1:0] LAST_ITER = IW'(MAX_ITER);

   vt_state_e       state_q, state_d;
   logic [IW-1:0]   iter_q, iter_d;
   logic [7:0]      err_q, err_d;
   logic            locked_q, locked_d;
   logic [2:0]      rot_q, rot_d;
   logic            done_q, done_d;
   logic            pass_q, pass_d;

   logic            hit;
   logic [2:0]      hit_rot;
   logic            word_bad;
   logic [7:0]      err_inc;

   valtrain_rot_match u_rot_match (
      .i_word  (i_RVLD_L),
      .o_match (hit),
      .o_rot   (hit_rot)
   );

   // Once locked, only the locked rotation is acceptable; other rotations are errors.
   assign word_bad = locked_q ? (i_RVLD_L != vt_pattern(rot_q)) : !hit;
   assign err_inc  = (err_q == 8'hFF) ? err_q : err_q + 8'd1;

   always_comb begin
      state_d  = state_q;
      iter_d   = iter_q;
      err_d    = err_q;
      locked_d = locked_q;
      rot_d    = rot_q;
      done_d   = done_q;
      pass_d   = pass_q;
      case (state_q)
         ST_IDLE: begin
            done_d = 1'b0;
            pass_d = 1'b0;
            if (i_enable) begin
               state_d  = ST_CHECK;
               iter_d   = '0;
               err_d    = 8'd0;
               locked_d = 1'b0;
               rot_d    = 3'd0;
            end
         end
         ST_CHECK: begin
            if (!i_enable) begin
               state_d  = ST_IDLE;
               iter_d   = '0;
               err_d    = 8'd0;
               locked_d = 1'b0;
               rot_d    = 3'd0;
               done_d   = 1'b0;
               pass_d   = 1'b0;
            end else if (i_rvld_strobe) begin
               iter_d = iter_q + 1'b1;
               if (!locked_q && hit) begin
                  locked_d = 1'b1;
                  rot_d    = hit_rot;
               end
               if (word_bad) begin
                  err_d = err_inc;
               end
               // The verdict uses the count including the final word.
               if (iter_d == LAST_ITER) begin
                  state_d = ST_DONE;
                  done_d  = 1'b1;
                  pass_d  = (32'(err_d) <= ERR_THRESHOLD);
               end
            end
         end
         ST_DONE: begin
            if (!i_enable) begin
               state_d = ST_IDLE;
               done_d  = 1'b0;
               pass_d  = 1'b0;
            end
         end
         default: begin
            state_d = ST_IDLE;
            done_d  = 1'b0;
            pass_d  = 1'b0;
         end
      endcase
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q  <= ST_IDLE;
         iter_q   <= '0;
         err_q    <= 8'd0;
         locked_q <= 1'b0;
         rot_q    <= 3'd0;
         done_q   <= 1'b0;
         pass_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         iter_q   <= iter_d;
         err_q    <= err_d;
         locked_q <= locked_d;
         rot_q    <= rot_d;
         done_q   <= done_d;
         pass_q   <= pass_d;
      end
   end

   assign o_done      = done_q;
   assign o_pass      = pass_q;
   assign o_err_count = err_q;
   assign o_locked    = locked_q;
   assign o_lock_rot  = rot_q;

endmodule

// File: tb/tb_valtrain_checker.sv
// Randomised bench for valtrain_checker against a word-list reference model.
module tb_valtrain_checker;

   logic        clk;
   logic        rst_n;
   logic        en;
   logic        stb;
   logic [31:0] dat;
   logic        done, pass, locked;
   logic [7:0]  errc;
   logic [2:0]  rot;

   int n_checks = 0;
   int n_fail   = 0;

   // Reference model state
   bit m_locked;
   int m_rot, m_err, m_iter;

   valtrain_checker #(.MAX_ITER(128), .ERR_THRESHOLD(16)) dut (
      .i_clk         (clk),
      .i_rst_n       (rst_n),
      .i_enable      (en),
      .i_rvld_strobe (stb),
      .i_RVLD_L      (dat),
      .o_done        (done),
      .o_pass        (pass),
      .o_err_count   (errc),
      .o_locked      (locked),
      .o_lock_rot    (rot)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [31:0] pat(input int r);
      logic [7:0] b;
      b = (8'hF0 >> r) | (8'hF0 << (8 - r));
      return {4{b}};
   endfunction

   function automatic bit is_pat(input logic [31:0] w);
      for (int r = 0; r < 8; r++) if (w == pat(r)) return 1'b1;
      return 1'b0;
   endfunction

   function automatic logic [31:0] garbage();
      logic [31:0] w;
      w = $urandom;
      if (is_pat(w)) w[0] = ~w[0];
      return w;
   endfunction

   task automatic model_start();
      m_locked = 0; m_rot = 0; m_err = 0; m_iter = 0;
   endtask

   task automatic model_accept(input logic [31:0] w);
      int found;
      m_iter++;
      if (!m_locked) begin
         found = -1;
         for (int r = 0; r < 8; r++) if (found < 0 && w == pat(r)) found = r;
         if (found >= 0) begin m_locked = 1; m_rot = found; end
         else m_err++;
      end else if (w != pat(m_rot)) m_err++;
      if (m_err > 255) m_err = 255;
   endtask

   task automatic send(input logic [31:0] w);
      stb = 1'b1; dat = w;
      @(posedge clk); #1;
      stb = 1'b0; dat = $urandom;
      model_accept(w);
   endtask

   task automatic start_run();
      en = 1'b1;
      @(posedge clk); #1;
      model_start();
   endtask

   task automatic stop_run();
      en = 1'b0;
      @(posedge clk); #1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; en = 1'b0; stb = 1'b0; dat = '0;
      #12;
      n_checks++;
      if ({done, pass, errc, locked, rot} !== 14'd0) begin
         n_fail++; $display("FAIL reset_outputs: got %h want 0", {done, pass, errc, locked, rot});
      end
      @(posedge clk); #1; rst_n = 1'b1;
      stb = 1'b1; dat = 32'h1234_5678;
      repeat (3) @(posedge clk);
      #1; stb = 1'b0;
      n_checks++;
      if (errc !== 8'd0 || done !== 1'b0) begin
         n_fail++; $display("FAIL idle_ignores_strobe: err=%0d done=%0d want 0 0", errc, done);
      end
   endtask

   task automatic test_pattern(input int r);
      start_run();
      for (int i = 0; i < 128; i++) begin
         send(pat(r));
         if (i == 0) begin
            n_checks++;
            if (locked !== 1'b1 || rot !== 3'(r)) begin
               n_fail++; $display("FAIL p%0d_first_lock: locked=%0d rot=%0d want 1 %0d", r, locked, rot, r);
            end
         end
         if (i < 127) begin
            n_checks++;
            if (done !== 1'b0) begin n_fail++; $display("FAIL p%0d_early_done word %0d: got 1 want 0", r, i + 1); end
         end
      end
      n_checks++;
      if (done !== 1'b1 || pass !== 1'b1 || errc !== 8'd0 || rot !== 3'(r)) begin
         n_fail++; $display("FAIL p%0d_final: done=%0d pass=%0d err=%0d rot=%0d want 1 1 0 %0d", r, done, pass, errc, rot, r);
      end
      stb = 1'b1; dat = garbage();
      @(posedge clk); #1; stb = 1'b0;
      n_checks++;
      if (done !== 1'b1 || pass !== 1'b1 || errc !== 8'd0) begin
         n_fail++; $display("FAIL p%0d_done_hold: done=%0d pass=%0d err=%0d want 1 1 0", r, done, pass, errc);
      end
      stop_run();
      n_checks++;
      if (done !== 1'b0 || pass !== 1'b0 || locked !== 1'b1 || rot !== 3'(r)) begin
         n_fail++; $display("FAIL p%0d_release: done=%0d pass=%0d locked=%0d rot=%0d want 0 0 1 %0d", r, done, pass, locked, rot, r);
      end
   endtask

   task automatic test_threshold(input int nerr, input bit exp_pass);
      bit bad [128];
      int placed = 0;
      int p;
      for (int i = 0; i < 128; i++) bad[i] = 1'b0;
      while (placed < nerr) begin
         p = $urandom_range(127, 1);
         if (!bad[p]) begin bad[p] = 1'b1; placed++; end
      end
      start_run();
      for (int i = 0; i < 128; i++) begin
         send(bad[i] ? 32'hF0F0_F0F1 : pat(0));
         n_checks++;
         if (errc !== 8'(m_err)) begin
            n_fail++; $display("FAIL thr%0d_err word %0d: got %0d want %0d", nerr, i + 1, errc, m_err);
         end
      end
      n_checks++;
      if (done !== 1'b1 || errc !== 8'(nerr) || pass !== exp_pass) begin
         n_fail++; $display("FAIL thr%0d_final: done=%0d err=%0d pass=%0d want 1 %0d %0d", nerr, done, errc, pass, nerr, exp_pass);
      end
      stop_run();
      n_checks++;
      if (done !== 1'b0 || pass !== 1'b0 || errc !== 8'(nerr)) begin
         n_fail++; $display("FAIL thr%0d_retain: done=%0d pass=%0d err=%0d want 0 0 %0d", nerr, done, pass, errc, nerr);
      end
   endtask

   task automatic test_garbage_lock(input bit inject_p0);
      start_run();
      for (int i = 0; i < 3; i++) begin
         send(garbage());
         n_checks++;
         if (locked !== 1'b0 || errc !== 8'(i + 1)) begin
            n_fail++; $display("FAIL garb_word%0d: locked=%0d err=%0d want 0 %0d", i + 1, locked, errc, i + 1);
         end
      end
      send(pat(2));
      n_checks++;
      if (locked !== 1'b1 || rot !== 3'd2 || errc !== 8'd3) begin
         n_fail++; $display("FAIL garb_lock4: locked=%0d rot=%0d err=%0d want 1 2 3", locked, rot, errc);
      end
      for (int i = 4; i < 128; i++) begin
         if (inject_p0 && i == 100) begin
            send(pat(0));
            n_checks++;
            if (errc !== 8'd4 || locked !== 1'b1 || rot !== 3'd2) begin
               n_fail++; $display("FAIL garb_p0_error: err=%0d locked=%0d rot=%0d want 4 1 2", errc, locked, rot);
            end
         end else send(pat(2));
      end
      n_checks++;
      if (done !== 1'b1 || pass !== 1'b1 || rot !== 3'd2 || errc !== (inject_p0 ? 8'd4 : 8'd3)) begin
         n_fail++; $display("FAIL garb_final: done=%0d pass=%0d rot=%0d err=%0d want 1 1 2 %0d", done, pass, rot, errc, inject_p0 ? 4 : 3);
      end
      stop_run();
   endtask

   task automatic test_sparse();
      int cycles = 0;
      int first_done = -1;
      start_run();
      for (int i = 0; i < 128; i++) begin
         send(($urandom_range(7) == 0) ? garbage() : pat(3));
         cycles++;
         if (done === 1'b1 && first_done < 0) first_done = cycles;
         if (i < 127) begin
            @(posedge clk); #1;
            cycles++;
            n_checks++;
            if (done !== 1'b0 || errc !== 8'(m_err)) begin
               n_fail++; $display("FAIL sparse_gap word %0d: done=%0d err=%0d want 0 %0d", i + 1, done, errc, m_err);
            end
         end
      end
      n_checks++;
      if (first_done !== 255 || pass !== (m_err <= 16) || errc !== 8'(m_err)) begin
         n_fail++; $display("FAIL sparse_done: first_done=%0d pass=%0d err=%0d want 255 %0d %0d", first_done, pass, errc, m_err <= 16, m_err);
      end
      stop_run();
   endtask

   task automatic test_abort_enable();
      start_run();
      for (int i = 0; i < 50; i++) send(($urandom_range(3) == 0) ? garbage() : pat(4));
      n_checks++;
      if (errc !== 8'(m_err)) begin n_fail++; $display("FAIL abort50_err: got %0d want %0d", errc, m_err); end
      en = 1'b0; stb = 1'b1; dat = pat(4);
      @(posedge clk); #1; stb = 1'b0;
      n_checks++;
      if ({done, pass, errc, locked, rot} !== 14'd0) begin
         n_fail++; $display("FAIL abort_en_clear: got %h want 0", {done, pass, errc, locked, rot});
      end
      start_run();
      for (int i = 0; i < 127; i++) send(pat(0));
      en = 1'b0; stb = 1'b1; dat = pat(0);
      @(posedge clk); #1; stb = 1'b0;
      n_checks++;
      if (done !== 1'b0 || errc !== 8'd0 || locked !== 1'b0) begin
         n_fail++; $display("FAIL abort_final_word: done=%0d err=%0d locked=%0d want 0 0 0", done, errc, locked);
      end
      start_run();
      for (int i = 0; i < 128; i++) begin
         send(pat(0));
         if (i == 126) begin
            n_checks++;
            if (done !== 1'b0) begin n_fail++; $display("FAIL abort_rerun_127: done=1 want 0"); end
         end
      end
      n_checks++;
      if (done !== 1'b1 || pass !== 1'b1) begin
         n_fail++; $display("FAIL abort_rerun_128: done=%0d pass=%0d want 1 1", done, pass);
      end
      stop_run();
   endtask

   task automatic test_abort_reset();
      start_run();
      for (int i = 0; i < 50; i++) send(($urandom_range(4) == 0) ? garbage() : pat(5));
      stb = 1'b1; dat = pat(5);
      #2 rst_n = 1'b0;
      #1;
      n_checks++;
      if ({done, pass, errc, locked, rot} !== 14'd0) begin
         n_fail++; $display("FAIL async_reset_clear: got %h want 0", {done, pass, errc, locked, rot});
      end
      stb = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      @(posedge clk); #1;
      model_start();
      for (int i = 0; i < 128; i++) begin
         send(pat(5));
         if (i == 126) begin
            n_checks++;
            if (done !== 1'b0) begin n_fail++; $display("FAIL reset_rerun_127: done=1 want 0"); end
         end
      end
      n_checks++;
      if (done !== 1'b1 || pass !== 1'b1 || rot !== 3'd5 || errc !== 8'd0) begin
         n_fail++; $display("FAIL reset_rerun_128: done=%0d pass=%0d rot=%0d err=%0d want 1 1 5 0", done, pass, rot, errc);
      end
      stop_run();
   endtask

   task automatic test_random();
      int base, sel;
      logic [31:0] w;
      for (int run = 0; run < 4; run++) begin
         base = $urandom_range(7);
         start_run();
         for (int i = 0; i < 128; i++) begin
            sel = $urandom_range(19);
            if (sel < 14)      w = pat(base);
            else if (sel < 16) w = pat($urandom_range(7));
            else               w = garbage();
            send(w);
            n_checks++;
            if (errc !== 8'(m_err) || locked !== m_locked || rot !== 3'(m_rot) || done !== (m_iter == 128)) begin
               n_fail++;
               $display("FAIL rand%0d word %0d: err=%0d locked=%0d rot=%0d done=%0d want %0d %0d %0d %0d",
                        run, i + 1, errc, locked, rot, done, m_err, m_locked, m_rot, m_iter == 128);
            end
            repeat ($urandom_range(2)) @(posedge clk);
            #1;
         end
         n_checks++;
         if (pass !== (m_err <= 16)) begin
            n_fail++; $display("FAIL rand%0d_pass: got %0d want %0d (err %0d)", run, pass, m_err <= 16, m_err);
         end
         stop_run();
      end
   endtask

   initial begin
      test_reset();
      test_pattern(0);
      test_pattern(1);
      test_threshold(16, 1'b1);
      test_threshold(17, 1'b0);
      test_garbage_lock(1'b0);
      test_garbage_lock(1'b1);
      test_sparse();
      test_abort_enable();
      test_abort_reset();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
